// File: rtl/cc_screen_wipe_selector.sv
// ---------------------------------------------------------------------------
// cc_screen_wipe_selector
//
// Chooses one of NSRC row-major LED-matrix images and presents it, registered,
// to the matrix scan driver. A source change is either immediate or a timed
// top-down wipe that replaces one row every STEP_DIV cycles. Sources whose
// BORDER_MASK bit is set have columns 0 and COLS-1 forced on in every row.
//
// Ports
//   SCREEN_WIPE_CLOCK_50      in   1               single clock
//   SCREEN_WIPE_RESET_InHigh  in   1               synchronous active-high reset
//   sel_in                    in   SEL_W           requested source index
//   wipe_en_in                in   1               1 = wipe, 0 = immediate switch
//   src_bus_in                in   NSRC*ROWS*COLS  source s = [s*ROWS*COLS +: ROWS*COLS]
//   img_bus_out               out  ROWS*COLS       registered displayed image
//   cur_sel_out               out  SEL_W           committed source index
//   busy_out                  out  1               high while a wipe runs
//
// Image layout: row r occupies bits [r*COLS +: COLS]; row ROWS-1 is the top.
// ---------------------------------------------------------------------------
module cc_screen_wipe_selector #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int NSRC     = 2,
  parameter int SEL_W    = 1,
  parameter int STEP_DIV = 4,
  parameter logic [NSRC-1:0] BORDER_MASK = 2'b01
) (
  input  logic                      SCREEN_WIPE_CLOCK_50,
  input  logic                      SCREEN_WIPE_RESET_InHigh,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      wipe_en_in,
  input  logic [NSRC*ROWS*COLS-1:0] src_bus_in,
  output logic [ROWS*COLS-1:0]      img_bus_out,
  output logic [SEL_W-1:0]          cur_sel_out,
  output logic                      busy_out
);

  localparam int IMG_W = ROWS * COLS;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RD_W  = $clog2(ROWS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [RD_W-1:0]  RD_LAST   = RD_W'(ROWS - 1);
  localparam logic [RD_W-1:0]  RD_FULL   = RD_W'(ROWS);
  localparam logic [SEL_W:0]   NSRC_EXT  = (SEL_W + 1)'(NSRC);
  // Bit 0 and bit COLS-1 of a row; collapses to a single bit when COLS == 1.
  localparam logic [COLS-1:0]  BORDER_BITS = COLS'(1) | (COLS'(1) << (COLS - 1));

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WIPE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [SEL_W-1:0]   cur_sel_q,   cur_sel_d;
  logic [SEL_W-1:0]   next_sel_q,  next_sel_d;
  logic [RD_W-1:0]    rows_done_q, rows_done_d;
  logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
  logic               busy_q,      busy_d;
  logic [IMG_W-1:0]   img_q,       img_d;

  // -------------------------------------------------------------------------
  // Per-source rendering (border forcing)
  // -------------------------------------------------------------------------
  logic [NSRC-1:0][IMG_W-1:0] render_img;

  genvar gi, gr;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      for (gr = 0; gr < ROWS; gr++) begin : g_row
        logic [COLS-1:0] raw_row;
        assign raw_row = src_bus_in[gi*IMG_W + gr*COLS +: COLS];
        if (BORDER_MASK[gi]) begin : g_border
          assign render_img[gi][gr*COLS +: COLS] = raw_row | BORDER_BITS;
        end else begin : g_plain
          assign render_img[gi][gr*COLS +: COLS] = raw_row;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Source lookup for the committed and the pending selection. A loop is used
  // instead of direct indexing because SEL_W may exceed clog2(NSRC).
  // -------------------------------------------------------------------------
  logic [IMG_W-1:0] cur_img;
  logic [IMG_W-1:0] next_img;

  always_comb begin
    cur_img  = '0;
    next_img = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (cur_sel_q == SEL_W'(s)) begin
        cur_img = render_img[s];
      end
      if (next_sel_q == SEL_W'(s)) begin
        next_img = render_img[s];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Wipe composite: row r takes the new source once rows_done >= ROWS-r,
  // so the new image grows downward from the top row.
  // -------------------------------------------------------------------------
  logic [IMG_W-1:0] wipe_img;

  generate
    for (gr = 0; gr < ROWS; gr++) begin : g_wipe_row
      localparam logic [RD_W-1:0] ROW_THR = RD_W'(ROWS - gr);
      assign wipe_img[gr*COLS +: COLS] = (rows_done_q >= ROW_THR)
                                         ? next_img[gr*COLS +: COLS]
                                         : cur_img[gr*COLS +: COLS];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Request detection: out-of-range selections are dropped silently.
  // -------------------------------------------------------------------------
  logic sel_valid;
  logic sel_req;

  assign sel_valid = ({1'b0, sel_in} < NSRC_EXT);
  assign sel_req   = sel_valid && (sel_in != cur_sel_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    next_sel_d  = next_sel_q;
    rows_done_d = rows_done_q;
    div_cnt_d   = div_cnt_q;
    busy_d      = busy_q;
    img_d       = cur_img;

    case (state_q)
      ST_IDLE: begin
        img_d = cur_img;
        if (sel_req) begin
          if (wipe_en_in) begin
            next_sel_d  = sel_in;
            rows_done_d = '0;
            div_cnt_d   = '0;
            busy_d      = 1'b1;
            state_d     = ST_WIPE;
          end else begin
            cur_sel_d = sel_in;
          end
        end
      end

      ST_WIPE: begin
        // Inputs are deliberately not looked at here; a pending request is
        // picked up only once IDLE is re-entered.
        img_d = wipe_img;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (rows_done_q == RD_LAST) begin
            // Last row step: commit the new source and hold rows_done at its
            // terminal value rather than wrapping.
            rows_done_d = RD_FULL;
            cur_sel_d   = next_sel_q;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            rows_done_d = rows_done_q + RD_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge SCREEN_WIPE_CLOCK_50) begin
    if (SCREEN_WIPE_RESET_InHigh) begin
      state_q     <= ST_IDLE;
      cur_sel_q   <= '0;
      next_sel_q  <= '0;
      rows_done_q <= '0;
      div_cnt_q   <= '0;
      busy_q      <= 1'b0;
      img_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      next_sel_q  <= next_sel_d;
      rows_done_q <= rows_done_d;
      div_cnt_q   <= div_cnt_d;
      busy_q      <= busy_d;
      img_q       <= img_d;
    end
  end

  assign img_bus_out = img_q;
  assign cur_sel_out = cur_sel_q;
  assign busy_out    = busy_q;

endmodule

// File: tb/tb_cc_screen_wipe_selector.sv
// ---------------------------------------------------------------------------
// Directed testbench for cc_screen_wipe_selector (8x8, two sources, border on
// source 0, four cycles per wipe step). SEL_W is widened to 2 so that an
// out-of-range selection (3) can be driven.
// ---------------------------------------------------------------------------
module tb_cc_screen_wipe_selector;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sel;
  logic         wipe_en;
  logic [127:0] src;
  logic [63:0]  img;
  logic [1:0]   cur_sel;
  logic         busy;

  int n_checks = 0;
  int n_bad    = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  cc_screen_wipe_selector #(
    .ROWS(8), .COLS(8), .NSRC(2), .SEL_W(2), .STEP_DIV(4), .BORDER_MASK(2'b01)
  ) dut (
    .SCREEN_WIPE_CLOCK_50    (clk),
    .SCREEN_WIPE_RESET_InHigh(rst),
    .sel_in                  (sel),
    .wipe_en_in              (wipe_en),
    .src_bus_in              (src),
    .img_bus_out             (img),
    .cur_sel_out             (cur_sel),
    .busy_out                (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("pass %s val=%h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] fill(input logic [7:0] row);
    return {8{row}};
  endfunction

  // Expected wipe frame with k rows replaced, counted from the top (row 7).
  function automatic logic [63:0] wipe_exp(input int k, input logic [7:0] nrow,
                                           input logic [7:0] orow);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      v[r*8 +: 8] = (r >= 8 - k) ? nrow : orow;
    end
    return v;
  endfunction

  initial begin
    // ---- 1: reset with arbitrary inputs ----
    rst     = 1'b1;
    sel     = 2'd1;
    wipe_en = 1'b1;
    src     = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) tick;
    check_val("rst_img",  img,           64'h0);
    check_val("rst_cur",  64'(cur_sel),  64'h0);
    check_val("rst_busy", 64'(busy),     64'h0);

    src     = {fill(8'h3C), fill(8'h00)};
    sel     = 2'd0;
    wipe_en = 1'b0;
    rst     = 1'b0;
    tick;
    check_val("rel_img", img, fill(8'h81));

    // ---- 2: immediate switch to source 1 ----
    sel = 2'd1;
    tick;
    check_val("imm_cur",      64'(cur_sel), 64'd1);
    check_val("imm_img_old",  img,          fill(8'h81));
    tick;
    check_val("imm_img_new",  img,          fill(8'h3C));
    check_val("imm_busy",     64'(busy),    64'h0);

    // back to source 0 immediately
    sel = 2'd0;
    tick;
    tick;
    check_val("imm_back_cur", 64'(cur_sel), 64'd0);
    check_val("imm_back_img", img,          fill(8'h81));

    // ---- 3/4: wipe 0 -> 1 with sel toggled during the wipe ----
    src     = {fill(8'hFF), fill(8'h00)};
    sel     = 2'd1;
    wipe_en = 1'b1;
    tick;
    check_val("wipe_start_busy", 64'(busy),    64'd1);
    check_val("wipe_start_cur",  64'(cur_sel), 64'd0);
    busy_cnt = 1;
    for (int e = 1; e <= 32; e++) begin
      if (e == 5) sel = 2'd0;
      if (e == 9) sel = 2'd1;
      tick;
      if (busy) busy_cnt++;
      if (e % 4 == 1) begin
        check_val($sformatf("wipe_k%0d", (e - 1) / 4), img,
                  wipe_exp((e - 1) / 4, 8'hFF, 8'h81));
      end
      if (e == 16) check_val("wipe_mid_cur", 64'(cur_sel), 64'd0);
    end
    check_val("wipe_end_busy", 64'(busy),     64'd0);
    check_val("wipe_end_cur",  64'(cur_sel),  64'd1);
    check_val("wipe_busy_len", 64'(busy_cnt), 64'd32);
    tick;
    check_val("wipe_final_img",  img,       fill(8'hFF));
    check_val("wipe_final_busy", 64'(busy), 64'd0);

    // out-of-range selection in IDLE
    sel = 2'd3;
    tick;
    tick;
    check_val("oor_busy", 64'(busy),    64'd0);
    check_val("oor_cur",  64'(cur_sel), 64'd1);
    check_val("oor_img",  img,          fill(8'hFF));

    // ---- 5: re-request held through wipe end ----
    sel     = 2'd0;
    wipe_en = 1'b0;
    tick;
    tick;
    check_val("pre5_cur", 64'(cur_sel), 64'd0);
    sel     = 2'd1;
    wipe_en = 1'b1;
    tick;
    sel = 2'd0;
    for (int e = 1; e <= 32; e++) tick;
    check_val("rereq_gap_busy", 64'(busy),    64'd0);
    check_val("rereq_gap_cur",  64'(cur_sel), 64'd1);
    tick;
    check_val("rereq_busy", 64'(busy),    64'd1);
    check_val("rereq_cur",  64'(cur_sel), 64'd1);
    check_val("rereq_img",  img,          fill(8'hFF));
    for (int e = 1; e <= 12; e++) begin
      tick;
      if (e == 5) check_val("rereq_k1", img, wipe_exp(1, 8'h81, 8'hFF));
      if (e == 9) check_val("rereq_k2", img, wipe_exp(2, 8'h81, 8'hFF));
    end

    // ---- 6: reset at rows_done = 3 ----
    rst = 1'b1;
    tick;
    check_val("midrst_img",  img,          64'h0);
    check_val("midrst_busy", 64'(busy),    64'h0);
    check_val("midrst_cur",  64'(cur_sel), 64'h0);
    rst = 1'b0;
    tick;
    check_val("post_rst_img",  img,       fill(8'h81));
    check_val("post_rst_busy", 64'(busy), 64'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
